// File: rtl/game_collision_scorer.sv
// game_collision_scorer: samples bird/pipe positions on each frame tick, detects collisions,
// counts passed pipes (binary and BCD), keeps the best score and raises game over.
module game_collision_scorer #(
  parameter int BIRD_X          = 160,
  parameter int BIRD_SIZE       = 24,
  parameter int PIPE_WIDTH      = 52,
  parameter int PIPE_GAP_HEIGHT = 100,
  parameter int GROUND_Y        = 400,
  parameter int SCORE_MAX       = 9999
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic [1:0]         iState,
  input  logic               iFrameTick,
  input  logic signed [16:0] iBirdY,
  input  logic signed [16:0] iPipe1X,
  input  logic signed [16:0] iPipe1Y,
  input  logic signed [16:0] iPipe2X,
  input  logic signed [16:0] iPipe2Y,
  input  logic signed [16:0] iPipe3X,
  input  logic signed [16:0] iPipe3Y,
  output logic               oHit,
  output logic               oGameOver,
  output logic               oPassPulse,
  output logic [13:0]        oScore,
  output logic [15:0]        oScoreBcd,
  output logic [13:0]        oBestScore
);

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Add 0..3 to a 4-digit BCD value, rippling the carry digit by digit.
  function automatic logic [15:0] bcd_add(input logic [15:0] b, input logic [1:0] n);
    logic [4:0] d;
    logic [1:0] c;
    bcd_add = b;
    c       = n;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, b[4*i +: 4]} + {3'b000, c};
      if (d > 5'd9) begin
        d = d - 5'd10;
        c = 2'd1;
      end else begin
        c = 2'd0;
      end
      bcd_add[4*i +: 4] = d[3:0];
    end
  endfunction

  localparam logic signed [17:0] L_BX   = 18'(BIRD_X);
  localparam logic signed [17:0] L_BS   = 18'(BIRD_SIZE);
  localparam logic signed [17:0] L_PW   = 18'(PIPE_WIDTH);
  localparam logic signed [17:0] L_GAP  = 18'(PIPE_GAP_HEIGHT);
  localparam logic signed [17:0] L_GY   = 18'(GROUND_Y);
  localparam logic signed [17:0] L_ZERO = 18'sd0;
  localparam logic signed [17:0] L_NONE = -18'sd1;
  localparam logic [13:0]        L_SMAX = 14'(SCORE_MAX);
  localparam logic [15:0]        L_BCD_MAX = to_bcd(SCORE_MAX);

  typedef enum logic [1:0] {StIdle, StPlay, StDead} state_e;

  state_e             r_state, w_state_nxt;
  logic               w_accept, w_commit, w_hold;
  logic signed [17:0] w_by;
  logic signed [17:0] w_px [3];
  logic signed [17:0] w_py [3];
  logic [2:0]         w_valid, w_ovl, w_phit, w_pass, w_rearm;
  logic               w_edge_hit;
  logic [2:0]         r_passed, w_passed_nxt;
  logic               r_s1_vld, r_s1_hit;
  logic [2:0]         r_s1_pass, r_s1_rearm;
  logic [1:0]         w_cnt;
  logic [14:0]        w_sum;
  logic [13:0]        r_score, w_score_nxt, r_best;
  logic [15:0]        r_bcd, w_bcd_nxt;
  logic               r_hit, r_go, r_pass_pulse;

  assign w_by    = {iBirdY[16], iBirdY};
  assign w_px[0] = {iPipe1X[16], iPipe1X};
  assign w_py[0] = {iPipe1Y[16], iPipe1Y};
  assign w_px[1] = {iPipe2X[16], iPipe2X};
  assign w_py[1] = {iPipe2Y[16], iPipe2Y};
  assign w_px[2] = {iPipe3X[16], iPipe3X};
  assign w_py[2] = {iPipe3Y[16], iPipe3Y};

  assign w_accept = (r_state == StPlay) && (iState == 2'd1) && iFrameTick;
  assign w_commit = r_s1_vld && (r_state == StPlay) && (iState == 2'd1);
  // Frozen play keeps a pending stage-1 result until play resumes.
  assign w_hold   = (r_state == StPlay) && iState[1];

  // Passed flags as they will be after this cycle, so back-to-back ticks never double count.
  always_comb begin
    w_passed_nxt = r_passed;
    if (iState == 2'd0) begin
      w_passed_nxt = '0;
    end else if (w_commit) begin
      w_passed_nxt = (r_passed | r_s1_pass) & ~r_s1_rearm;
    end
  end

  // Stage-1 geometry: per-pipe overlap, hit, pass and rearm terms.
  always_comb begin
    w_valid = '0;
    w_ovl   = '0;
    w_phit  = '0;
    w_pass  = '0;
    w_rearm = '0;
    for (int i = 0; i < 3; i++) begin
      w_valid[i] = (w_py[i] != L_NONE);
      w_ovl[i]   = (w_px[i] < L_BX + L_BS) && (w_px[i] + L_PW > L_BX);
      w_phit[i]  = w_valid[i] && w_ovl[i] &&
                   ((w_by < w_py[i]) || (w_by + L_BS > w_py[i] + L_GAP));
      w_pass[i]  = w_valid[i] && !w_passed_nxt[i] && (w_px[i] + L_PW <= L_BX);
      w_rearm[i] = (w_px[i] > L_BX + L_BS) || !w_valid[i];
    end
  end

  assign w_edge_hit = (w_by + L_BS > L_GY) || (w_by < L_ZERO);

  assign w_cnt = {1'b0, r_s1_pass[0]} + {1'b0, r_s1_pass[1]} + {1'b0, r_s1_pass[2]};
  assign w_sum = {1'b0, r_score} + {13'd0, w_cnt};

  // Stage-2 score update with saturation; BCD follows the binary value digit by digit.
  always_comb begin
    w_score_nxt = w_sum[13:0];
    w_bcd_nxt   = bcd_add(r_bcd, w_cnt);
    if (w_sum >= 15'(SCORE_MAX)) begin
      w_score_nxt = L_SMAX;
      w_bcd_nxt   = L_BCD_MAX;
    end
  end

  // Game FSM next state; iState==0 returns to idle from anywhere.
  always_comb begin
    w_state_nxt = r_state;
    if (iState == 2'd0) begin
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle:  if (iState == 2'd1) w_state_nxt = StPlay;
        StPlay:  if (w_commit && r_s1_hit) w_state_nxt = StDead;
        StDead:  w_state_nxt = StDead;
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge iClock) begin
    if (iReset) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  // Pipeline stages, score, pulses, game over and best score.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_passed     <= '0;
      r_s1_vld     <= 1'b0;
      r_s1_hit     <= 1'b0;
      r_s1_pass    <= '0;
      r_s1_rearm   <= '0;
      r_score      <= '0;
      r_bcd        <= '0;
      r_best       <= '0;
      r_hit        <= 1'b0;
      r_go         <= 1'b0;
      r_pass_pulse <= 1'b0;
    end else begin
      r_hit        <= 1'b0;
      r_pass_pulse <= 1'b0;
      r_passed     <= w_passed_nxt;
      r_s1_vld     <= w_accept || (w_hold && r_s1_vld);
      if (w_accept) begin
        r_s1_hit   <= w_edge_hit || (|w_phit);
        r_s1_pass  <= w_pass;
        r_s1_rearm <= w_rearm;
      end
      if (iState == 2'd0) begin
        r_score <= '0;
        r_bcd   <= '0;
        r_go    <= 1'b0;
      end else if (w_commit) begin
        r_score      <= w_score_nxt;
        r_bcd        <= w_bcd_nxt;
        r_pass_pulse <= (w_cnt != 2'd0);
        if (r_s1_hit) begin
          r_hit <= 1'b1;
          r_go  <= 1'b1;
          if (w_score_nxt > r_best) r_best <= w_score_nxt;
        end
      end
    end
  end

  assign oHit       = r_hit;
  assign oGameOver  = r_go;
  assign oPassPulse = r_pass_pulse;
  assign oScore     = r_score;
  assign oScoreBcd  = r_bcd;
  assign oBestScore = r_best;

endmodule

// File: tb/tb_game_collision_scorer.sv
// tb_game_collision_scorer: directed scenarios plus random play checked against a
// tick-level reference model of the scoring and collision rules.
module tb_game_collision_scorer;

  logic               iClock = 1'b0;
  logic               iReset;
  logic [1:0]         iState;
  logic               iFrameTick;
  logic signed [16:0] iBirdY;
  logic signed [16:0] iPipe1X, iPipe1Y, iPipe2X, iPipe2Y, iPipe3X, iPipe3Y;
  logic               oHit, oGameOver, oPassPulse;
  logic [13:0]        oScore, oBestScore;
  logic [15:0]        oScoreBcd;

  game_collision_scorer dut (
    .iClock(iClock), .iReset(iReset), .iState(iState), .iFrameTick(iFrameTick),
    .iBirdY(iBirdY), .iPipe1X(iPipe1X), .iPipe1Y(iPipe1Y), .iPipe2X(iPipe2X),
    .iPipe2Y(iPipe2Y), .iPipe3X(iPipe3X), .iPipe3Y(iPipe3Y), .oHit(oHit),
    .oGameOver(oGameOver), .oPassPulse(oPassPulse), .oScore(oScore),
    .oScoreBcd(oScoreBcd), .oBestScore(oBestScore)
  );

  always #5 iClock = ~iClock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ticks are resolved immediately in game order; their visible effect
  // is queued and released at the next edge where play is active.
  typedef struct { int score; bit pass; bit hit; } rec_t;
  rec_t q[$];
  int   m_score, m_mode;   // mode: 0 idle, 1 play, 2 dead
  bit   m_passed[3];
  bit   m_dead;
  int   v_score, v_best;
  bit   v_hit, v_pp, v_go;

  function automatic int bcd_of(input int s);
    return ((s / 1000) << 12) | (((s / 100) % 10) << 8) | (((s / 10) % 10) << 4) | (s % 10);
  endfunction

  task automatic clear_game();
    m_score = 0; m_dead = 0; m_passed = '{0, 0, 0};
    v_score = 0; v_go = 0; q.delete();
  endtask

  task automatic model_tick();
    int  by, px[3], py[3], cnt;
    bit  hit, valid, ovl;
    rec_t r;
    by = iBirdY;
    px[0] = iPipe1X; py[0] = iPipe1Y;
    px[1] = iPipe2X; py[1] = iPipe2Y;
    px[2] = iPipe3X; py[2] = iPipe3Y;
    hit = (by + 24 > 400) || (by < 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      valid = (py[i] != -1);
      ovl   = (px[i] < 160 + 24) && (px[i] + 52 > 160);
      if (valid && ovl && ((by < py[i]) || (by + 24 > py[i] + 100))) hit = 1;
      if (valid && !m_passed[i] && (px[i] + 52 <= 160)) begin
        cnt++;
        m_passed[i] = 1;
      end else if ((px[i] > 184) || !valid) begin
        m_passed[i] = 0;
      end
    end
    m_score = (m_score + cnt > 9999) ? 9999 : m_score + cnt;
    r.score = m_score; r.pass = (cnt > 0); r.hit = hit;
    q.push_back(r);
    if (hit) m_dead = 1;
  endtask

  task automatic model_edge();
    bit   acc;
    rec_t r;
    v_hit = 0; v_pp = 0;
    if (iReset) begin
      clear_game(); v_best = 0; m_mode = 0;
    end else if (iState == 2'd0) begin
      clear_game(); m_mode = 0;
    end else begin
      acc = (m_mode == 1) && (iState == 2'd1) && iFrameTick;
      if ((q.size() > 0) && (m_mode == 1) && (iState == 2'd1)) begin
        r = q.pop_front();
        v_score = r.score; v_pp = r.pass;
        if (r.hit) begin
          v_hit = 1; v_go = 1; m_mode = 2;
          if (r.score > v_best) v_best = r.score;
        end
      end
      if (acc && !m_dead) model_tick();
      if ((m_mode == 0) && (iState == 2'd1)) m_mode = 1;
    end
  endtask

  task automatic run_cycle();
    @(posedge iClock);
    model_edge();
    #1;
    check_eq("hit", 32'(oHit), 32'(v_hit));
    check_eq("pass_pulse", 32'(oPassPulse), 32'(v_pp));
    check_eq("game_over", 32'(oGameOver), 32'(v_go));
    check_eq("score", 32'(oScore), 32'(v_score));
    check_eq("score_bcd", 32'(oScoreBcd), 32'(bcd_of(v_score)));
    check_eq("best", 32'(oBestScore), 32'(v_best));
    @(negedge iClock);
  endtask

  task automatic drive(input int st, input bit tk, input int by, input int x1, input int y1,
                       input int x2, input int y2, input int x3, input int y3);
    iState = 2'(st); iFrameTick = tk; iBirdY = 17'(by);
    iPipe1X = 17'(x1); iPipe1Y = 17'(y1);
    iPipe2X = 17'(x2); iPipe2Y = 17'(y2);
    iPipe3X = 17'(x3); iPipe3Y = 17'(y3);
  endtask

  task automatic one(input int st, input bit tk, input int by, input int x1, input int y1);
    drive(st, tk, by, x1, y1, 400, -1, 400, -1);
    run_cycle();
  endtask

  // Score n pipes in one tick, then rearm all of them on the next tick.
  task automatic pass_step(input int n);
    drive(1, 1, 150, 100, (n > 0) ? 120 : -1, 100, (n > 1) ? 120 : -1, 100, (n > 2) ? 120 : -1);
    run_cycle();
    drive(1, 1, 150, 400, -1, 400, -1, 400, -1);
    run_cycle();
  endtask

  function automatic int rand_x();
    int edges[8] = '{107, 108, 109, 183, 184, 185, -60, 640};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 7)];
    return int'($urandom_range(0, 420)) - 60;
  endfunction

  function automatic int rand_y();
    if ($urandom_range(0, 3) == 0) return -1;
    return int'($urandom_range(0, 300));
  endfunction

  function automatic int rand_by();
    int edges[5] = '{-2, -1, 0, 376, 377};
    if ($urandom_range(0, 4) == 0) return edges[$urandom_range(0, 4)];
    return int'($urandom_range(40, 300));
  endfunction

  initial begin
    clear_game(); v_best = 0; m_mode = 0;
    iReset = 1'b1;
    drive(0, 0, 150, 400, -1, 400, -1, 400, -1);
    run_cycle();
    run_cycle();
    check_eq("rst_score", 32'(oScore), 32'd0);
    check_eq("rst_game_over", 32'(oGameOver), 32'd0);
    iReset = 1'b0;

    // Basic pass, no double count, rearm and second pass.
    one(1, 0, 150, 300, 120);
    for (int i = 0; i < 3; i++) one(1, 1, 150, 300, 120);
    one(1, 1, 150, 107, 120);
    one(1, 0, 150, 107, 120);
    check_eq("t1_pass_pulse", 32'(oPassPulse), 32'd1);
    check_eq("t1_score1", 32'(oScore), 32'd1);
    check_eq("t1_bcd1", 32'(oScoreBcd), 32'h0001);
    for (int i = 0; i < 3; i++) one(1, 1, 150, 107, 120);
    one(1, 1, 150, 640, 120);
    one(1, 1, 150, 100, 120);
    one(1, 0, 150, 100, 120);
    one(1, 0, 150, 100, 120);
    check_eq("t1_score2", 32'(oScore), 32'd2);

    // Pipe body hit two cycles after the tick, then frozen score.
    one(1, 1, 110, 170, 120);
    check_eq("t2_no_early_hit", 32'(oHit), 32'd0);
    one(1, 0, 110, 170, 120);
    check_eq("t2_hit", 32'(oHit), 32'd1);
    check_eq("t2_game_over", 32'(oGameOver), 32'd1);
    one(1, 1, 150, 640, 120);
    one(1, 1, 150, 100, 120);
    one(1, 0, 150, 100, 120);
    one(1, 0, 150, 100, 120);
    check_eq("t2_score_frozen", 32'(oScore), 32'd2);
    check_eq("t2_best", 32'(oBestScore), 32'd2);
    one(0, 0, 110, 400, -1);
    one(1, 0, 110, 108, 120);
    one(1, 1, 110, 108, 120);
    one(1, 0, 110, 108, 120);
    one(1, 0, 110, 108, 120);
    check_eq("t2_edge_touch", 32'(oGameOver), 32'd0);

    // Ground and ceiling.
    one(1, 1, 377, 400, -1);
    one(1, 0, 377, 400, -1);
    check_eq("t3_ground_hit", 32'(oGameOver), 32'd1);
    one(0, 0, 376, 400, -1);
    one(1, 0, 376, 400, -1);
    one(1, 1, 376, 400, -1);
    one(1, 0, 376, 400, -1);
    check_eq("t3_ground_ok", 32'(oGameOver), 32'd0);
    one(1, 1, -1, 400, -1);
    one(1, 0, -1, 400, -1);
    check_eq("t3_ceiling_hit", 32'(oGameOver), 32'd1);

    // Digit carry and saturation.
    one(0, 0, 150, 400, -1);
    one(1, 0, 150, 400, -1);
    for (int i = 0; i < 9; i++) pass_step(1);
    check_eq("t4_bcd9", 32'(oScoreBcd), 32'h0009);
    pass_step(1);
    check_eq("t4_bcd10", 32'(oScoreBcd), 32'h0010);
    for (int i = 0; i < 3329; i++) pass_step(3);
    check_eq("t4_score9997", 32'(oScore), 32'd9997);
    pass_step(1);
    pass_step(1);
    check_eq("t4_score_max", 32'(oScore), 32'd9999);
    check_eq("t4_bcd_max", 32'(oScoreBcd), 32'h9999);
    pass_step(3);
    check_eq("t4_saturated", 32'(oScore), 32'd9999);

    // Same-tick pass and hit; best score survives idle.
    iReset = 1'b1;
    one(0, 0, 150, 400, -1);
    iReset = 1'b0;
    one(1, 0, 150, 400, -1);
    for (int i = 0; i < 4; i++) pass_step(1);
    one(1, 1, 380, 100, 120);
    one(1, 0, 380, 100, 120);
    check_eq("t5_score", 32'(oScore), 32'd5);
    check_eq("t5_game_over", 32'(oGameOver), 32'd1);
    check_eq("t5_best", 32'(oBestScore), 32'd5);
    one(0, 0, 150, 400, -1);
    check_eq("t5_idle_score", 32'(oScore), 32'd0);
    check_eq("t5_idle_best", 32'(oBestScore), 32'd5);
    one(1, 0, 150, 400, -1);
    for (int i = 0; i < 3; i++) pass_step(1);
    one(1, 1, 380, 400, -1);
    one(1, 0, 380, 400, -1);
    check_eq("t5_best_kept", 32'(oBestScore), 32'd5);

    // Flush mid-pipeline, then reset mid-game.
    one(0, 0, 150, 400, -1);
    one(1, 0, 150, 400, -1);
    one(1, 1, -1, 400, -1);
    one(0, 0, -1, 400, -1);
    check_eq("t6_flush_hit", 32'(oHit), 32'd0);
    check_eq("t6_flush_go", 32'(oGameOver), 32'd0);
    one(1, 0, 150, 400, -1);
    pass_step(1);
    pass_step(1);
    iReset = 1'b1;
    one(1, 1, 150, 100, 120);
    check_eq("t6_rst_best", 32'(oBestScore), 32'd0);
    check_eq("t6_rst_score", 32'(oScore), 32'd0);
    iReset = 1'b0;

    // Random play including freezes, restarts and occasional resets.
    for (int n = 0; n < 4000; n++) begin
      int r;
      iReset = ($urandom_range(0, 199) == 0);
      r = int'($urandom_range(0, 99));
      drive((r < 80) ? 1 : (r < 88) ? 0 : (r < 94) ? 2 : 3, ($urandom_range(0, 9) < 7),
            rand_by(), rand_x(), rand_y(), rand_x(), rand_y(), rand_x(), rand_y());
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
